decoder_scan_nto2n: RTL and testbench

- Parametrised, registered N-to-2^N decoder with enable. It generalises the team's 3-to-8 enable decoder.
- Adds an auto-scan mode: an internal prescaled counter steps the selected lane round-robin. This is used for multiplexed 7-seg digit drive and LED strobing.
- Sits between control logic (or a free-running scan) and per-lane output drivers.

---
 rtl/decoder_pkg.sv | 25 ++
 rtl/scan_prescaler.sv | 30 +++
 rtl/decoder_scan_nto2n.sv | 99 +++++++++
 tb/tb_decoder_scan_nto2n.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning N-to-2^N decoder.
// onehot() supports select widths up to MAX_SEL_W.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_OUT_W = 2**MAX_SEL_W;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_OUT_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Divide-by-DIV step counter; tick_c marks the last count of each scan period.
module scan_prescaler
  import decoder_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic tick_c
);

  localparam int unsigned PRE_W = (clog2(DIV) == 0) ? 1 : clog2(DIV);

  logic [PRE_W-1:0] cnt;

  assign tick_c = !clear && !hold && (cnt == PRE_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= tick_c ? '0 : cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N decoder with enable and prescaled round-robin auto-scan.
// Optional lane skipping is compiled in with `define DECODER_SKIP_EN.
module decoder_scan_nto2n
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned DIV        = 4,
  parameter bit          ACTIVE_LOW = 1'b0,
  localparam int unsigned OUT_W     = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] a,
`ifdef DECODER_SKIP_EN
  input  logic [OUT_W-1:0] skip_mask,
`endif
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  logic             prev_mode;
  logic             scan_step_c, load_c, hold_c, tick_c;
  logic [SEL_W-1:0] step_idx_c, nxt_idx_c;
  logic             step_wrap_c, nxt_wrap_c, lane_masked_c;
  logic [OUT_W-1:0] nxt_y_c;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (load_c),
    .hold   (hold_c),
    .tick_c (tick_c)
  );

`ifdef DECODER_SKIP_EN
  // Priority search for the first unmasked lane after idx; a lower result means we wrapped.
  always_comb begin : skip_search
    logic             found;
    logic [SEL_W-1:0] cand;
    found       = 1'b0;
    cand        = '0;
    step_idx_c  = idx;
    step_wrap_c = 1'b0;
    for (int unsigned k = 1; k < OUT_W; k++) begin
      cand = idx + SEL_W'(k);
      if (!found && !skip_mask[cand]) begin
        found       = 1'b1;
        step_idx_c  = cand;
        step_wrap_c = (cand < idx);
      end
    end
  end

  assign lane_masked_c = skip_mask[nxt_idx_c];
`else
  assign step_idx_c    = idx + SEL_W'(1);
  assign step_wrap_c   = (idx == SEL_W'(OUT_W - 1));
  assign lane_masked_c = 1'b0;
`endif

  // Direct mode and scan entry both load a; only a steady scan advances.
  always_comb begin
    scan_step_c = en && (mode == MODE_SCAN) && (prev_mode == MODE_SCAN);
    load_c      = en && !scan_step_c;
    hold_c      = !scan_step_c;
    nxt_idx_c   = idx;
    nxt_wrap_c  = 1'b0;
    if (load_c) begin
      nxt_idx_c = a;
    end else if (scan_step_c && tick_c) begin
      nxt_idx_c  = step_idx_c;
      nxt_wrap_c = step_wrap_c;
    end
  end

  always_comb begin
    nxt_y_c = '0;
    if (en && !lane_masked_c) nxt_y_c = OUT_W'(onehot(MAX_SEL_W'(nxt_idx_c)));
    if (ACTIVE_LOW) nxt_y_c = ~nxt_y_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= ACTIVE_LOW ? '1 : '0;
      idx       <= '0;
      wrap      <= 1'b0;
      prev_mode <= MODE_DIRECT;
    end else begin
      y         <= nxt_y_c;
      idx       <= nxt_idx_c;
      wrap      <= nxt_wrap_c;
      prev_mode <= mode;
    end
  end

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Bench for decoder_scan_nto2n: two configurations checked every cycle against a lane-level model,
// plus hand-computed literal checks. Define DECODER_SKIP_EN to also exercise lane skipping.
module tb_decoder_scan_nto2n;

  typedef struct {
    int idx;
    int pre;
    bit prev;
    int lane;
    bit wrap;
  } mstate_t;

  int sw [2] = '{3, 2};
  int dv [2] = '{4, 1};
  bit al [2] = '{1'b0, 1'b1};

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [2:0] a;
  logic [7:0] skip;
  logic [7:0] y1;
  logic [2:0] idx1;
  logic       wrap1;
  logic [3:0] y2;
  logic [1:0] idx2;
  logic       wrap2;

  int tests;
  int fails;
  bit started;
  mstate_t m [2];

  decoder_scan_nto2n dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .a         (a),
`ifdef DECODER_SKIP_EN
    .skip_mask (skip),
`endif
    .y         (y1),
    .idx       (idx1),
    .wrap      (wrap1)
  );

  decoder_scan_nto2n #(.SEL_W(2), .DIV(1), .ACTIVE_LOW(1'b1)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .a         (a[1:0]),
`ifdef DECODER_SKIP_EN
    .skip_mask (skip[3:0]),
`endif
    .y         (y2),
    .idx       (idx2),
    .wrap      (wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mstate_t reset_state();
    mstate_t r;
    r.idx = 0; r.pre = 0; r.prev = 1'b0; r.lane = -1; r.wrap = 1'b0;
    return r;
  endfunction

  // Lane-level reference: which lane is lit, where the scan stands, and whether it just wrapped.
  function automatic mstate_t model_next(int i, mstate_t s, bit e, bit md, int av, int mk);
    mstate_t r;
    int n;
    n = 1 << sw[i];
    r = s;
    r.prev = md;
    r.wrap = 1'b0;
    if (!e) begin
      r.lane = -1;
      return r;
    end
    if (!md || !s.prev) begin
      r.idx = av % n;
      r.pre = 0;
    end else if (s.pre == dv[i] - 1) begin
      r.pre = 0;
      for (int k = 1; k < n; k++) begin
        if (((mk >> ((s.idx + k) % n)) & 1) == 0) begin
          r.idx  = (s.idx + k) % n;
          r.wrap = (s.idx + k >= n);
          break;
        end
      end
    end else begin
      r.pre = s.pre + 1;
    end
    r.lane = (((mk >> r.idx) & 1) != 0) ? -1 : r.idx;
    return r;
  endfunction

  function automatic logic [7:0] exp_y(int i, int lane);
    logic [7:0] v;
    int n;
    n = 1 << sw[i];
    v = (lane >= 0) ? 8'(1 << lane) : 8'h00;
    if (al[i]) v = ~v & 8'((1 << n) - 1);
    return v;
  endfunction

  function automatic int mask_now();
`ifdef DECODER_SKIP_EN
    return int'(skip);
`else
    return 0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) m[i] <= reset_state();
    end else begin
      for (int i = 0; i < 2; i++) m[i] <= model_next(i, m[i], en, mode, int'(a), mask_now());
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_y", 32'(y1), 32'(exp_y(0, m[0].lane)));
      chk("model_idx", 32'(idx1), 32'(m[0].idx));
      chk("model_wrap", 32'(wrap1), 32'(m[0].wrap));
      chk("model_y2", 32'(y2), 32'(exp_y(1, m[1].lane)));
      chk("model_idx2", 32'(idx2), 32'(m[1].idx));
      chk("model_wrap2", 32'(wrap2), 32'(m[1].wrap));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] dl_seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    tests = 0; fails = 0; started = 1'b0;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; a = 3'd0; skip = 8'h00;
    step(3);
    started = 1'b1;
    rst_n = 1'b1; en = 1'b1; a = 3'd3;
    step();
    chk("pre_reset_y", 32'(y1), 32'h08);

    // Asynchronous reset mid-cycle while a lane is lit.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y", 32'(y1), 32'h00);
    chk("async_rst_idx", 32'(idx1), 32'h0);
    chk("async_rst_wrap", 32'(wrap1), 32'h0);
    chk("async_rst_y2", 32'(y2), 32'hF);
    step();
    rst_n = 1'b1; mode = 1'b0; a = 3'd5;
    step();
    chk("release_y", 32'(y1), 32'h20);

    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      step();
      chk("sweep_y", 32'(y1), 32'(1 << i));
      chk("sweep_idx", 32'(idx1), 32'(i));
    end
    a = 3'd4;
    step();
    en = 1'b0;
    step();
    chk("dis_y", 32'(y1), 32'h00);
    chk("dis_idx", 32'(idx1), 32'd4);
    en = 1'b1;

    // Scan entry at lane 6, DIV=4.
    a = 3'd6; mode = 1'b1;
    step();
    chk("entry_y", 32'(y1), 32'h40);
    for (int s = 1; s <= 4; s++) begin
      step();
      chk("scan_y6", 32'(y1), (s < 4) ? 32'h40 : 32'h80);
    end
    for (int s = 1; s <= 4; s++) begin
      step();
      chk("scan_y7", 32'(y1), (s < 4) ? 32'h80 : 32'h01);
      chk("scan_wrap", 32'(wrap1), (s < 4) ? 32'h0 : 32'h1);
    end
    step();
    chk("wrap_once", 32'(wrap1), 32'h0);
    step(3);
    chk("scan_y1", 32'(y1), 32'h02);
    step(4);
    step(2);
    chk("frz_start_idx", 32'(idx1), 32'd2);

    en = 1'b0;
    for (int s = 0; s < 10; s++) begin
      step();
      chk("frz_y", 32'(y1), 32'h00);
      chk("frz_idx", 32'(idx1), 32'd2);
      chk("frz_wrap", 32'(wrap1), 32'h0);
    end
    en = 1'b1;
    step();
    chk("resume_y", 32'(y1), 32'h04);
    step();
    chk("resume_step_y", 32'(y1), 32'h08);
    chk("resume_step_idx", 32'(idx1), 32'd3);
    chk("resume_wrap", 32'(wrap1), 32'h0);

    // DIV=1 active-low instance stepping every cycle.
    mode = 1'b0; a = 3'd0;
    step();
    mode = 1'b1;
    step();
    chk("al_entry_y2", 32'(y2), 32'hE);
    for (int s = 0; s < 4; s++) begin
      step();
      chk("al_y2", 32'(y2), 32'(dl_seq[s]));
      chk("al_wrap2", 32'(wrap2), (s == 3) ? 32'h1 : 32'h0);
    end

`ifdef DECODER_SKIP_EN
    skip = 8'b1011_0110; mode = 1'b0; a = 3'd0;
    step();
    mode = 1'b1;
    step();
    chk("skip_entry_y", 32'(y1), 32'h01);
    step(4);
    chk("skip_idx3", 32'(idx1), 32'd3);
    step(4);
    chk("skip_idx6", 32'(idx1), 32'd6);
    chk("skip_y6", 32'(y1), 32'h40);
    step(4);
    chk("skip_idx0", 32'(idx1), 32'd0);
    chk("skip_wrap", 32'(wrap1), 32'h1);
    skip = 8'hFF;
    for (int s = 0; s < 6; s++) begin
      step();
      chk("allmask_y", 32'(y1), 32'h00);
      chk("allmask_idx", 32'(idx1), 32'd0);
      chk("allmask_wrap", 32'(wrap1), 32'h0);
    end
    skip = 8'h00;
`endif

    // Randomised traffic; mode only changes while enabled.
    for (int c = 0; c < 3000; c++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(199) == 0) rst_n = 1'b0;
      en = ($urandom_range(7) != 0);
      if (en && $urandom_range(15) == 0) mode = ~mode;
      a = 3'($urandom);
`ifdef DECODER_SKIP_EN
      if ($urandom_range(7) == 0) skip = 8'($urandom);
      else if ($urandom_range(7) == 0) skip = 8'h00;
`endif
      step();
    end
    rst_n = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
